// File: rtl/bloom_pkg.sv
// Shared constants for the bloom filter query and insert sides: hash keys,
// hash count and the query FSM states. Both sides must import this package
// so that the generated indices agree.
package bloom_pkg;

  localparam int NUM_HASH = 3;
  localparam int KW       = 2;  // width of the hash counter

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [0:NUM_HASH-1][7:0] HASH_KEY = {8'h9D, 8'h3B, 8'hE7};

  // Key lookup that stays in range for the unused counter code.
  function automatic logic [7:0] hash_key(input logic [KW-1:0] k);
    case (k)
      2'd0:    hash_key = HASH_KEY[0];
      2'd1:    hash_key = HASH_KEY[1];
      default: hash_key = HASH_KEY[2];
    endcase
  endfunction

endpackage

// File: rtl/bloom_hash_idx.sv
// Multiplicative hash: full-width product of key and data, index taken
// from the most significant $clog2(BL_SIZE) bits of the product.
module bloom_hash_idx #(
  parameter int D_SIZE  = 8,
  parameter int BL_SIZE = 16
) (
  input  logic [D_SIZE-1:0]          key,
  input  logic [D_SIZE-1:0]          data,
  output logic [$clog2(BL_SIZE)-1:0] idx
);

  localparam int IW = $clog2(BL_SIZE);
  localparam int PW = 2 * D_SIZE;

  logic [PW-1:0] prod;

  assign prod = {{D_SIZE{1'b0}}, key} * {{D_SIZE{1'b0}}, data};
  // Top bits of the product carry the best mixing of the key bits.
  assign idx  = IW'(prod >> (PW - IW));

endmodule

// File: rtl/bloom_check.sv
// Bloom filter membership check. One query at a time: the key is hashed
// three times through a single shared multiplier (one hash per cycle)
// against a snapshot of the filter taken at acceptance.
// Optional macro BLOOM_EARLY_EXIT_EN: finish as soon as a probed bit is 0.
module bloom_check
  import bloom_pkg::*;
#(
  parameter int D_SIZE  = 8,
  parameter int BL_SIZE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [BL_SIZE-1:0] load_vec,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [D_SIZE-1:0]  q_data,
  output logic               r_valid,
  output logic               r_hit,
  input  logic               r_ready,
  output logic [BL_SIZE-1:0] filter
);

  localparam int IW = $clog2(BL_SIZE);

  state_t             state, state_nxt;
  logic [KW-1:0]      k;
  logic [D_SIZE-1:0]  data;
  logic [BL_SIZE-1:0] snap;
  logic               acc;
  logic [IW-1:0]      idx;
  logic               bit_k;
  logic               accept;
  logic               last_k;

  bloom_hash_idx #(.D_SIZE(D_SIZE), .BL_SIZE(BL_SIZE)) u_hash (
    .key  (D_SIZE'(hash_key(k))),
    .data (data),
    .idx  (idx)
  );

  assign bit_k   = snap[idx];
  assign accept  = q_valid && (state == IDLE);
  assign last_k  = (k == KW'(NUM_HASH - 1));
  assign q_ready = (state == IDLE);
  assign r_valid = (state == DONE);
  assign r_hit   = r_valid & acc;

  // Stored filter; reset wins over a concurrent load.
  always_ff @(posedge clk) begin
    if (reset)           filter <= '0;
    else if (load_valid) filter <= load_vec;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = HASH;
      HASH: begin
        if (last_k) state_nxt = DONE;
`ifdef BLOOM_EARLY_EXIT_EN
        if (!bit_k) state_nxt = DONE;
`endif
      end
      DONE:    if (r_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Query datapath: capture key and pre-load filter, then fold one probe per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      k    <= '0;
      data <= '0;
      snap <= '0;
      acc  <= 1'b0;
    end else if (accept) begin
      k    <= '0;
      data <= q_data;
      snap <= filter;
      acc  <= 1'b1;
    end else if (state == HASH) begin
      acc <= acc & bit_k;
      k   <= (state_nxt == DONE) ? '0 : k + 1'b1;
    end
  end

endmodule

// File: tb/tb_bloom_check.sv
// Randomized self-checking bench for bloom_check with an arithmetic
// reference model of the hashes, snapshot and expected latency.
module tb_bloom_check;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_vec;
  logic        q_valid;
  logic        q_ready;
  logic [7:0]  q_data;
  logic        r_valid;
  logic        r_hit;
  logic        r_ready;
  logic [15:0] filter;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] mfilter;

  bloom_check #(.D_SIZE(8), .BL_SIZE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_vec   (load_vec),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_data     (q_data),
    .r_valid    (r_valid),
    .r_hit      (r_hit),
    .r_ready    (r_ready),
    .filter     (filter)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index = top 4 bits of a 16-bit product, i.e. product / 4096.
  function automatic int midx(input int k, input int d);
    int keys[3] = '{157, 59, 231};
    return (keys[k] * d) / 4096;
  endfunction

  task automatic do_load(input logic [15:0] v);
    load_valid = 1'b1;
    load_vec   = v;
    tick();
    load_valid = 1'b0;
    mfilter    = v;
    chk("filter_load", filter, mfilter);
  endtask

  task automatic run_query(input logic [7:0] d, input bit ld_acc, input logic [15:0] ld_v,
                           input int hold, input bit mid_loads);
    logic [15:0] snap, nv;
    bit hit, found, did_ld;
    int lat_exp, early, cyc;
    chk("q_ready_idle", q_ready, 1);
    snap  = mfilter;
    hit   = 1'b1;
    found = 1'b0;
    early = 3;
    for (int k = 0; k < 3; k++) begin
      if (!snap[midx(k, d)]) begin
        hit = 1'b0;
        if (!found) begin found = 1'b1; early = k + 1; end
      end
    end
    lat_exp = 3;
`ifdef BLOOM_EARLY_EXIT_EN
    lat_exp = early;
`endif
    r_ready = (hold == 0);
    q_valid = 1'b1;
    q_data  = d;
    if (ld_acc) begin load_valid = 1'b1; load_vec = ld_v; end
    tick();
    q_valid    = 1'b0;
    load_valid = 1'b0;
    if (ld_acc) mfilter = ld_v;
    chk("filter_acc", filter, mfilter);
    cyc = 0;
    while (!r_valid && cyc < 8) begin
      chk("q_ready_busy", q_ready, 0);
      did_ld = 1'b0;
      if (mid_loads && ($urandom % 2 == 1)) begin
        nv = 16'($urandom);
        load_valid = 1'b1;
        load_vec   = nv;
        did_ld     = 1'b1;
      end
      tick();
      load_valid = 1'b0;
      if (did_ld) mfilter = nv;
      cyc++;
      chk("filter_mid", filter, mfilter);
    end
    chk("latency", cyc, lat_exp);
    chk("r_hit", r_hit, hit);
    if (hold == 0) begin
      tick();
      chk("r_valid_pulse", r_valid, 0);
      chk("q_ready_after", q_ready, 1);
      r_ready = 1'b0;
    end else begin
      repeat (hold) begin
        tick();
        chk("r_valid_hold", r_valid, 1);
        chk("r_hit_hold", r_hit, hit);
        chk("q_ready_hold", q_ready, 0);
      end
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      chk("r_valid_drop", r_valid, 0);
      chk("q_ready_back", q_ready, 1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_vec   = '0;
    q_valid    = 1'b0;
    q_data     = '0;
    r_ready    = 1'b0;
    mfilter    = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_filter", filter, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_hit", r_hit, 0);
    chk("rst_q_ready", q_ready, 1);

    // Directed cases
    chk("idx0", midx(0, 255), 9);
    do_load(16'h4208);
    run_query(8'hFF, 1'b0, '0, 0, 1'b0);   // all three probes hit
    do_load(16'h0208);
    run_query(8'hFF, 1'b0, '0, 0, 1'b0);   // miss on k=2
    do_load(16'h0001);
    run_query(8'h01, 1'b0, '0, 0, 1'b0);   // all probes at index 0
    do_load(16'h0000);
    run_query(8'h01, 1'b0, '0, 0, 1'b0);   // miss on k=0
    do_load(16'h4208);
    run_query(8'hFF, 1'b0, '0, 10, 1'b0);  // consumer stalls
    do_load(16'h0000);
    run_query(8'hFF, 1'b1, 16'hFFFF, 0, 1'b0);  // load coincides with accept
    run_query(8'hFF, 1'b0, '0, 2, 1'b1);   // snapshot isolation

    // Reset in the middle of a query, with a competing load
    do_load(16'hFFFF);
    q_valid = 1'b1;
    q_data  = 8'h5A;
    tick();                      // E0
    q_valid = 1'b0;
    tick();                      // E1
    reset      = 1'b1;
    load_valid = 1'b1;
    load_vec   = 16'hFFFF;
    tick();                      // E2
    reset      = 1'b0;
    load_valid = 1'b0;
    mfilter    = '0;
    chk("midrst_filter", filter, 0);
    chk("midrst_q_ready", q_ready, 1);
    repeat (5) begin
      chk("midrst_no_r_valid", r_valid, 0);
      tick();
    end

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 3 == 0) do_load(16'($urandom));
      run_query(8'($urandom), ($urandom % 4 == 0), 16'($urandom),
                int'($urandom_range(0, 3)), ($urandom % 2 == 1));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
